fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream consumer of the 512x8 byte FIFO. It pops one byte at a time through the FIFO's rd_en/rd_data/empty interface and serialises each byte as a UART frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. It is the TX path between the FIFO and the board pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range is 2 or more.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 gives even parity and 1 gives odd; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  permits fetching a new byte; does not abort a frame in flight
fifo_empty  in  1  FIFO empty flag
fifo_rd_data  in  8  FIFO read data, registered in the FIFO, valid the cycle after the pop edge
fifo_rd_en  out  1  pop request; combinational
tx  out  1  serial line, idle high; registered
busy  out  1  high whenever state is not IDLE; registered
tx_done  out  1  one-cycle pulse when a frame completes; registered
frame_count  out  16  frames completed, wraps at 0xFFFF to 0; registered

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE, tx=1, busy=0, tx_done=0, frame_count=0, baud and bit counters=0, shift register=0. fifo_rd_en=0 while rst=1.
- fifo_rd_en = (state==IDLE) && enable && !fifo_empty && !rst. It is high for exactly one cycle per frame.
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If fifo_rd_en is high, go to LOAD at the next edge. The FIFO pops on that same edge.
- LOAD, one cycle: capture fifo_rd_data into the shift register, compute the parity bit (even = ^data, odd = ~^data), drive tx<=0, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: bit index runs 0..7, and tx=shift[index] for CLKS_PER_BIT cycles each, LSB first. After bit 7, go to PARITY if PARITY_EN, otherwise STOP.
- PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle's edge: go to IDLE, tx_done<=1 for one cycle, frame_count<=frame_count+1.
- Baud counter: width $clog2(CLKS_PER_BIT). It runs 0..CLKS_PER_BIT-1 and clears on every bit boundary and in IDLE/LOAD. Every bit lasts exactly CLKS_PER_BIT cycles, with no drift.
- Latency: tx falls 2 cycles after the first IDLE cycle in which enable && !fifo_empty holds (IDLE edge, then LOAD edge).
- Frame length in tx-low/data/stop cycles: (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT.
- Back-to-back frames: the minimum line-high gap between frames is STOP time plus 2 clk (IDLE + LOAD). There is no pop while busy.
- fifo_empty is ignored outside IDLE. A FIFO that goes empty or refills mid-frame has no effect on the current frame.
- enable dropped mid-frame: the current frame completes normally and no new pop follows. enable dropped in the same cycle as IDLE: no pop.
- rst mid-frame: tx=1 after the next edge and the partial byte is discarded. No pop occurs in the reset cycle or the cycle after it.
- frame_count wraps 0xFFFF -> 0x0000 with no flag.

Decomposition:
- uart_pkg holds the state enum (IDLE..STOP), constant DATA_BITS=8, and parity-mode constants.
- One sub-module is natural: uart_baud_counter. It takes parameter CLKS_PER_BIT, inputs clk, rst and clear, and outputs a bit_end pulse on count==CLKS_PER_BIT-1.
- The FSM, shift register, parity and frame counter stay in the top module.

Test Plan:
- Single byte (CLKS_PER_BIT=4, no parity, 1 stop): FIFO holds 0xA5, enable=1 -> one fifo_rd_en pulse. tx is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. tx_done pulses once, frame_count=1, and the total is 40 cycles from start edge to done.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x3C -> three frames in order, exactly 3 rd_en pulses, each inter-frame gap = stop + 2 clk, frame_count=3, and the FIFO ends empty with no further rd_en.
- Parity (PARITY_EN=1): byte 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0. STOP_BITS=2 -> stop high for 8 cycles.
- Enable gating: enable=0 with FIFO non-empty -> no rd_en and tx stays 1. Deassert enable mid-DATA of 0x5A -> that frame completes and no second pop follows.
- Reset mid-frame: assert rst during DATA bit 3 -> next edge gives tx=1, busy=0, frame_count=0, and no tx_done. After release, the next byte is sent intact.
- Wrap: force frame_count=0xFFFF, send one byte -> frame_count=0x0000 and tx_done pulses.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the FIFO-fed UART transmitter:
//            the transmitter state encoding, the data width of a UART
//            character and the parity-mode selectors.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_t;

    localparam int   c_data_bits   = 8;
    localparam logic c_parity_even = 1'b0;
    localparam logic c_parity_odd  = 1'b1;

    // Even parity makes the total count of ones even, so the bit equals the
    // XOR of the data; odd parity is its complement.
    function automatic logic parity_bit(input logic [c_data_bits-1:0] data,
                                        input logic                   mode);
        return (mode == c_parity_odd) ? ~^data : ^data;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_counter
// Purpose  : Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and
//            restarts on every bit boundary, so every bit is exactly
//            CLKS_PER_BIT clocks long.
// Ports    : clk     in  clock
//            rst     in  synchronous active-high reset
//            clear   in  hold the counter at zero
//            bit_end out high in the last clock of a bit period
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt_q;
    logic [c_cnt_w-1:0] w_cnt_d;

    assign bit_end = (r_cnt_q == c_last);

    always_comb begin
        w_cnt_d = r_cnt_q + c_cnt_w'(1);
        if (clear || bit_end) begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule : uart_baud_counter
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pops bytes from a registered-read FIFO and serialises each one
//            as a UART frame: start bit, 8 data bits LSB first, optional
//            parity bit, 1 or 2 stop bits.
// Ports    : clk          in  clock
//            rst          in  synchronous active-high reset
//            enable       in  permits fetching a new byte
//            fifo_empty   in  FIFO empty flag
//            fifo_rd_data in  FIFO read data, valid the cycle after the pop
//            fifo_rd_en   out pop request (combinational)
//            tx           out serial line, idle high
//            busy         out high whenever not idle
//            tx_done      out one-cycle pulse per completed frame
//            frame_count  out completed frames, wraps at 0xFFFF
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rd_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        tx_done,
    output logic [15:0] frame_count
);

    localparam logic [2:0] c_last_data_idx = 3'(c_data_bits - 1);
    localparam logic [2:0] c_last_stop_idx = 3'(STOP_BITS - 1);
    localparam logic       c_parity_mode   = (PARITY_ODD != 0) ? c_parity_odd : c_parity_even;

    uart_state_t            r_state_q, w_state_d;
    logic [c_data_bits-1:0] r_shift_q, w_shift_d;
    logic                   r_parity_q, w_parity_d;
    logic [2:0]             r_bit_idx_q, w_bit_idx_d;
    logic                   r_tx_q, w_tx_d;
    logic                   r_busy_q, w_busy_d;
    logic                   r_tx_done_q, w_tx_done_d;
    logic [15:0]            r_frame_count_q, w_frame_count_d;

    logic                   w_bit_end;
    logic                   w_baud_clear;
    logic [2:0]             w_next_idx;

    // The pop is issued from IDLE; the FIFO presents the byte during LOAD.
    assign fifo_rd_en   = (r_state_q == ST_IDLE) && enable && !fifo_empty && !rst;
    // Counter is held in IDLE/LOAD so START begins a fresh full bit period.
    assign w_baud_clear = (r_state_q == ST_IDLE) || (r_state_q == ST_LOAD);
    assign w_next_idx   = r_bit_idx_q + 3'd1;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_baud_clear),
        .bit_end(w_bit_end)
    );

    always_comb begin
        w_state_d       = r_state_q;
        w_shift_d       = r_shift_q;
        w_parity_d      = r_parity_q;
        w_bit_idx_d     = r_bit_idx_q;
        w_tx_d          = r_tx_q;
        w_tx_done_d     = 1'b0;
        w_frame_count_d = r_frame_count_q;

        case (r_state_q)
            ST_IDLE: begin
                w_tx_d = 1'b1;
                if (fifo_rd_en) begin
                    w_state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_shift_d   = fifo_rd_data;
                w_parity_d  = parity_bit(fifo_rd_data, c_parity_mode);
                w_bit_idx_d = 3'd0;
                w_tx_d      = 1'b0;
                w_state_d   = ST_START;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_tx_d      = r_shift_q[0];
                    w_bit_idx_d = 3'd0;
                    w_state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx_q == c_last_data_idx) begin
                        w_bit_idx_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            w_tx_d    = r_parity_q;
                            w_state_d = ST_PARITY;
                        end else begin
                            w_tx_d    = 1'b1;
                            w_state_d = ST_STOP;
                        end
                    end else begin
                        w_bit_idx_d = w_next_idx;
                        w_tx_d      = r_shift_q[w_next_idx];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_tx_d      = 1'b1;
                    w_bit_idx_d = 3'd0;
                    w_state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                // The bit index doubles as the stop-bit counter here.
                if (w_bit_end) begin
                    if (r_bit_idx_q == c_last_stop_idx) begin
                        w_bit_idx_d     = 3'd0;
                        w_tx_done_d     = 1'b1;
                        w_frame_count_d = r_frame_count_q + 16'd1;
                        w_state_d       = ST_IDLE;
                    end else begin
                        w_bit_idx_d = w_next_idx;
                    end
                end
            end
            default: begin
                w_tx_d    = 1'b1;
                w_state_d = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= ST_IDLE;
            r_shift_q       <= '0;
            r_parity_q      <= 1'b0;
            r_bit_idx_q     <= 3'd0;
            r_tx_q          <= 1'b1;
            r_busy_q        <= 1'b0;
            r_tx_done_q     <= 1'b0;
            r_frame_count_q <= 16'd0;
        end else begin
            r_state_q       <= w_state_d;
            r_shift_q       <= w_shift_d;
            r_parity_q      <= w_parity_d;
            r_bit_idx_q     <= w_bit_idx_d;
            r_tx_q          <= w_tx_d;
            r_busy_q        <= w_busy_d;
            r_tx_done_q     <= w_tx_done_d;
            r_frame_count_q <= w_frame_count_d;
        end
    end

    assign tx          = r_tx_q;
    assign busy        = r_busy_q;
    assign tx_done     = r_tx_done_q;
    assign frame_count = r_frame_count_q;

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx. Three instances share
//            clk/rst/enable: #0 no parity / 1 stop, #1 even parity / 2 stop,
//            #2 odd parity / 2 stop, all with 4 clocks per bit. Each has a
//            behavioural FIFO and a line receiver that decodes frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int C_CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ok;
        int         gap;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;

    logic        f_empty    [3];
    logic [7:0]  f_rd_data  [3];
    logic        f_rd_en    [3];
    logic        tx_w       [3];
    logic        busy_w     [3];
    logic        tx_done_w  [3];
    logic [15:0] fc_w       [3];

    logic [7:0]  fmem [3][64];
    int          wp   [3] = '{0, 0, 0};
    int          rp   [3] = '{0, 0, 0};

    logic [7:0]  expq   [3][$];
    frame_t      frames [3][$];
    int          lens   [3][$];
    int          pops   [3] = '{0, 0, 0};
    int          dones  [3] = '{0, 0, 0};

    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int c_pe   = (gi > 0) ? 1 : 0;
        localparam int c_odd  = (gi == 2) ? 1 : 0;
        localparam int c_stop = (gi > 0) ? 2 : 1;
        localparam int c_nb   = 1 + 8 + c_pe + c_stop;

        fifo_uart_tx #(
            .CLKS_PER_BIT(C_CPB),
            .PARITY_EN   (c_pe),
            .PARITY_ODD  (c_odd),
            .STOP_BITS   (c_stop)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable),
            .fifo_empty  (f_empty[gi]),
            .fifo_rd_data(f_rd_data[gi]),
            .fifo_rd_en  (f_rd_en[gi]),
            .tx          (tx_w[gi]),
            .busy        (busy_w[gi]),
            .tx_done     (tx_done_w[gi]),
            .frame_count (fc_w[gi])
        );

        // Registered-read FIFO model.
        assign f_empty[gi] = (wp[gi] == rp[gi]);
        always @(posedge clk) begin
            if (f_rd_en[gi]) begin
                f_rd_data[gi] <= fmem[gi][rp[gi] % 64];
                rp[gi]        <= rp[gi] + 1;
            end
        end

        // Line receiver: samples mid-bit, records frames, lengths and gaps.
        int          cnt        = 0;
        bit          active     = 0;
        logic [11:0] bits       = '0;
        int          since_fall = 0;
        int          since_done = 1000;
        int          cur_gap    = 0;
        frame_t      fr;

        always @(negedge clk) begin
            if (rst) begin
                active = 0;
            end else begin
                since_fall++;
                since_done++;
                if (f_rd_en[gi]) pops[gi]++;
                if (tx_done_w[gi]) begin
                    dones[gi]++;
                    lens[gi].push_back(since_fall);
                    since_done = 0;
                end
                if (!active && tx_w[gi] == 1'b0) begin
                    active     = 1;
                    cnt        = 0;
                    since_fall = 0;
                    cur_gap    = since_done;
                end
                if (active) begin
                    if (cnt % C_CPB == C_CPB / 2) bits[cnt / C_CPB] = tx_w[gi];
                    if (cnt == C_CPB * (c_nb - 1) + C_CPB / 2) begin
                        fr.data = bits[8:1];
                        fr.par  = bits[9];
                        fr.ok   = (bits[0] == 1'b0) && (bits[9 + c_pe] == 1'b1) && (bits[c_nb - 1] == 1'b1);
                        fr.gap  = cur_gap;
                        frames[gi].push_back(fr);
                        active = 0;
                    end
                    cnt++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int k, input logic [7:0] b);
        fmem[k][wp[k] % 64] = b;
        wp[k]++;
        expq[k].push_back(b);
    endtask

    task automatic wait_done(input int k, input int target, input string tag);
        for (int c = 0; c < 400; c++) begin
            if (dones[k] >= target) break;
            tick(1);
        end
        tick(2);
        chk(tag, dones[k], target);
    endtask

    task automatic wait_fall(input int k);
        for (int c = 0; c < 100; c++) begin
            if (tx_w[k] === 1'b0) break;
            tick(1);
        end
        chk("tx_fall", tx_w[k], 1'b0);
    endtask

    task automatic check_frame(input int k, input int len_exp, input int par_exp,
                               input int gap_exp, input string tag);
        frame_t     f;
        logic [7:0] want;
        int         len;
        logic       avail;
        avail = (frames[k].size() > 0) && (expq[k].size() > 0) && (lens[k].size() > 0);
        chk({tag, "_avail"}, avail, 1'b1);
        if (avail) begin
            f    = frames[k].pop_front();
            want = expq[k].pop_front();
            len  = lens[k].pop_front();
            chk({tag, "_data"}, f.data, want);
            chk({tag, "_framing"}, f.ok, 1'b1);
            chk({tag, "_len"}, len, len_exp);
            if (par_exp >= 0) chk({tag, "_parity"}, f.par, par_exp);
            if (gap_exp >= 0) chk({tag, "_gap"}, f.gap, gap_exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        tick(3);

        // Reset state and no pop while rst is high.
        chk("rst_tx", tx_w[0], 1'b1);
        chk("rst_busy", busy_w[0], 1'b0);
        chk("rst_tx_done", tx_done_w[0], 1'b0);
        chk("rst_frame_count", fc_w[0], 16'd0);
        enable = 1'b1;
        push(0, 8'hA5);
        #1;
        chk("rst_rd_en", f_rd_en[0], 1'b0);

        // Enable gating: FIFO non-empty but enable low.
        enable = 1'b0;
        rst    = 1'b0;
        tick(10);
        chk("gate_pops", pops[0], 0);
        chk("gate_tx", tx_w[0], 1'b1);
        chk("gate_rd_en", f_rd_en[0], 1'b0);

        // Single byte 0xA5 with latency check.
        enable = 1'b1;
        #1;
        chk("single_rd_en", f_rd_en[0], 1'b1);
        tick(1);
        chk("single_load_busy", busy_w[0], 1'b1);
        chk("single_load_tx", tx_w[0], 1'b1);
        tick(1);
        chk("single_start_tx", tx_w[0], 1'b0);
        wait_done(0, 1, "single_done");
        check_frame(0, 40, -1, -1, "single");
        chk("single_pops", pops[0], 1);
        chk("single_frame_count", fc_w[0], 16'd1);

        // Back-to-back frames.
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        wait_done(0, 4, "b2b_done");
        check_frame(0, 40, -1, -1, "b2b0");
        check_frame(0, 40, -1, 2, "b2b1");
        check_frame(0, 40, -1, 2, "b2b2");
        chk("b2b_frame_count", fc_w[0], 16'd4);
        tick(20);
        chk("b2b_pops", pops[0], 4);
        chk("b2b_empty", f_empty[0], 1'b1);
        chk("b2b_idle_tx", tx_w[0], 1'b1);

        // Enable dropped mid-DATA of 0x5A; 0x11 must stay in the FIFO.
        push(0, 8'h5A);
        push(0, 8'h11);
        wait_fall(0);
        tick(12);
        enable = 1'b0;
        wait_done(0, 5, "endrop_done");
        check_frame(0, 40, -1, -1, "endrop");
        tick(20);
        chk("endrop_pops", pops[0], 5);
        chk("endrop_not_empty", f_empty[0], 1'b0);
        chk("endrop_busy", busy_w[0], 1'b0);

        // Reset during data bit 3 of 0x11; that byte is discarded.
        enable = 1'b1;
        wait_fall(0);
        tick(17);
        rst = 1'b1;
        tick(1);
        chk("midrst_tx", tx_w[0], 1'b1);
        chk("midrst_busy", busy_w[0], 1'b0);
        chk("midrst_frame_count", fc_w[0], 16'd0);
        chk("midrst_tx_done", tx_done_w[0], 1'b0);
        push(0, 8'h96);
        #1;
        chk("midrst_rd_en", f_rd_en[0], 1'b0);
        tick(2);
        void'(expq[0].pop_front());
        rst = 1'b0;
        wait_done(0, 6, "postrst_done");
        check_frame(0, 40, -1, -1, "postrst");
        chk("postrst_frame_count", fc_w[0], 16'd1);

        // frame_count wrap.
        force g_dut[0].u_dut.r_frame_count_q = 16'hFFFF;
        tick(1);
        release g_dut[0].u_dut.r_frame_count_q;
        push(0, 8'hC3);
        wait_done(0, 7, "wrap_done");
        check_frame(0, 40, -1, -1, "wrap");
        chk("wrap_frame_count", fc_w[0], 16'd0);

        // Parity and two stop bits: 0x07 -> even parity 1, odd parity 0.
        push(1, 8'h07);
        push(2, 8'h07);
        wait_done(1, 1, "par_even_done");
        wait_done(2, 1, "par_odd_done");
        check_frame(1, 48, 1, -1, "par_even");
        check_frame(2, 48, 0, -1, "par_odd");
        chk("par_pops", pops[1], 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_fifo_uart_tx
`default_nettype wire
